clock_divider: RTL and testbench

Parameterised clock divider that derives a slower square-wave clock `clk_out` from `clk_in`. The output runs at 1/2^(p_factor+1) of the input frequency with a 50 % duty cycle. It sits between the board clock and downstream logic that needs a slow enable or display-rate clock. Reset puts the divider into a known low phase so its output phase is deterministic.

---
 rtl/clock_divider_pkg.sv | 13 +
 rtl/clock_divider_reset_sync.sv | 30 +++
 rtl/clock_divider.sv | 56 +++++
 tb/tb_clock_divider.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_divider_pkg.sv
// Shared constants for the clock divider: synchroniser depth, legal divide
// exponents and the counter width derived from the exponent.
package clock_divider_pkg;

   localparam int SYNC_STAGES  = 2;
   localparam int P_FACTOR_MIN = 1;
   localparam int P_FACTOR_MAX = 30;

   function automatic int cnt_width(input int p);
      return p + 1;
   endfunction

endpackage

// File: rtl/clock_divider_reset_sync.sv
// Active-low reset synchroniser: asserts asynchronously, releases after
// STAGES rising edges of clk_in.
module clock_divider_reset_sync
   import clock_divider_pkg::*;
#(
   parameter int STAGES = SYNC_STAGES
) (
   input  logic clk_in,
   input  logic rst_async_n,
   output logic rst_sync_n
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], 1'b1};
   end

   always_ff @(posedge clk_in or negedge rst_async_n) begin
      if (!rst_async_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign rst_sync_n = sync_q[STAGES-1];

endmodule

// File: rtl/clock_divider.sv
// Divides clk_in by 2^(p_factor+1) with 50 % duty; clk_out is the MSB of a
// free-running up-counter, so it comes straight from a flop.
module clock_divider
   import clock_divider_pkg::*;
#(
   parameter int p_factor = 2
) (
   input  logic clk_in,
   input  logic rst,
   output logic clk_out
);

   localparam int CNT_W = cnt_width(p_factor);

   if (p_factor < P_FACTOR_MIN || p_factor > P_FACTOR_MAX) begin : g_bad_param
      $error("clock_divider: p_factor must be within 1..30");
   end

   logic             rst_sync_n;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             running_q;
   logic             running_d;

   clock_divider_reset_sync #(
      .STAGES(SYNC_STAGES)
   ) u_reset_sync (
      .clk_in      (clk_in),
      .rst_async_n (rst),
      .rst_sync_n  (rst_sync_n)
   );

   // The first step after release jumps by the synchroniser depth, so the low
   // phase measured from the rst release cycle is exactly 2^p_factor cycles.
   always_comb begin
      running_d = 1'b1;
      if (running_q) begin
         count_d = count_q + CNT_W'(1);
      end else begin
         count_d = CNT_W'(SYNC_STAGES);
      end
   end

   always_ff @(posedge clk_in or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         count_q   <= '0;
         running_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         running_q <= running_d;
      end
   end

   assign clk_out = count_q[CNT_W-1];

endmodule

// File: tb/tb_clock_divider.sv
// Bench for clock_divider: three instances (p_factor 1, 2, 3) share clk_in
// and rst and are checked against a cycles-since-release reference model.
module tb_clock_divider;

   localparam int PF [3] = '{1, 2, 3};

   logic       clk_in = 1'b0;
   logic       rst    = 1'b1;
   logic [2:0] out_v;
   logic [2:0] exp_v;
   int         n      = -1;
   int         errors = 0;
   int         checks = 0;

   always #5 clk_in = ~clk_in;

   clock_divider #(.p_factor(1)) u_p1 (.clk_in(clk_in), .rst(rst), .clk_out(out_v[0]));
   clock_divider #(.p_factor(2)) u_p2 (.clk_in(clk_in), .rst(rst), .clk_out(out_v[1]));
   clock_divider #(.p_factor(3)) u_p3 (.clk_in(clk_in), .rst(rst), .clk_out(out_v[2]));

   // Cycle = negedge to negedge. rst is applied at the start, the rising edge
   // falls mid-cycle, and n counts cycles since the rst release cycle.
   task automatic set_rst(input logic r);
      @(negedge clk_in);
      rst = r;
      if (!r) n = -1;
      else    n = n + 1;
      for (int i = 0; i < 3; i++)
         exp_v[i] = r ? (((n >> PF[i]) % 2) == 1) : 1'b0;
   endtask

   task automatic drive_cycle(input logic r);
      set_rst(r);
      #9;
   endtask

   task automatic test_reset();
      drive_cycle(1'b0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_v[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset p_factor=%0d: clk_out=%b required 0", PF[i], out_v[i]);
         end
      end
   endtask

   task automatic test_basic();
      logic [8:0] tbl;
      tbl = 9'b011110000;
      for (int c = 0; c < 9; c++) begin
         drive_cycle(1'b1);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_v[i] !== exp_v[i]) begin
               errors++;
               $display("FAIL basic p_factor=%0d cycle=%0d: clk_out=%b required %b",
                        PF[i], c, out_v[i], exp_v[i]);
            end
         end
         checks++;
         if (out_v[1] !== tbl[c]) begin
            errors++;
            $display("FAIL basic_table cycle=%0d: clk_out=%b required %b", c, out_v[1], tbl[c]);
         end
      end
   endtask

   task automatic test_long_run();
      for (int c = 0; c < 32; c++) begin
         drive_cycle(1'b1);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_v[i] !== exp_v[i]) begin
               errors++;
               $display("FAIL long_run p_factor=%0d cycle=%0d: clk_out=%b required %b",
                        PF[i], c, out_v[i], exp_v[i]);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      int budget;
      budget = 0;
      // advance until the p_factor=2 instance is in its third high cycle
      while (!(((n >> 2) % 2) == 1 && (n % 4) == 2) && budget < 16) begin
         drive_cycle(1'b1);
         budget++;
      end
      checks++;
      if (out_v[1] !== 1'b1 || budget >= 16) begin
         errors++;
         $display("FAIL mid_reset_setup: clk_out=%b required 1 (cycles waited %0d)", out_v[1], budget);
      end
      set_rst(1'b0);
      #1;
      checks++;
      if (out_v !== 3'b000) begin
         errors++;
         $display("FAIL mid_reset_immediate: clk_out=%b required 000", out_v);
      end
      #8;
      drive_cycle(1'b0);
      checks++;
      if (out_v !== 3'b000) begin
         errors++;
         $display("FAIL mid_reset_hold: clk_out=%b required 000", out_v);
      end
      for (int c = 0; c < 16; c++) begin
         drive_cycle(1'b1);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_v[i] !== exp_v[i]) begin
               errors++;
               $display("FAIL mid_reset_restart p_factor=%0d cycle=%0d: clk_out=%b required %b",
                        PF[i], c, out_v[i], exp_v[i]);
            end
         end
      end
   endtask

   task automatic test_async_glitch();
      int budget;
      budget = 0;
      while (!((((n + 1) >> 2) % 2) == 1) && budget < 16) begin
         drive_cycle(1'b1);
         budget++;
      end
      set_rst(1'b1);
      #6;
      checks++;
      if (out_v[1] !== 1'b1 || budget >= 16) begin
         errors++;
         $display("FAIL glitch_setup: clk_out=%b required 1 (cycles waited %0d)", out_v[1], budget);
      end
      rst = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (out_v !== 3'b000) begin
         errors++;
         $display("FAIL glitch_clear: clk_out=%b required 000 before next edge", out_v);
      end
      n = -1;
      exp_v = 3'b000;
      #1;
      checks++;
      if (out_v !== 3'b000) begin
         errors++;
         $display("FAIL glitch_cycle_end: clk_out=%b required 000", out_v);
      end
      for (int c = 0; c < 20; c++) begin
         drive_cycle(1'b1);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_v[i] !== exp_v[i]) begin
               errors++;
               $display("FAIL glitch_restart p_factor=%0d cycle=%0d: clk_out=%b required %b",
                        PF[i], c, out_v[i], exp_v[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      int lo_len;
      int hi_len;
      for (int s = 0; s < 8; s++) begin
         lo_len = $urandom_range(1, 3);
         hi_len = $urandom_range(4, 40);
         for (int c = 0; c < lo_len + hi_len; c++) begin
            drive_cycle(c >= lo_len);
            for (int i = 0; i < 3; i++) begin
               checks++;
               if (out_v[i] !== exp_v[i]) begin
                  errors++;
                  $display("FAIL random seg=%0d p_factor=%0d cycle=%0d: clk_out=%b required %b",
                           s, PF[i], c, out_v[i], exp_v[i]);
               end
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      exp_v = 3'b000;
      test_reset();
      test_basic();
      test_long_run();
      test_mid_reset();
      test_async_glitch();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
